iot_device_port: RTL



---
 rtl/io_bus_pkg.sv | 21 ++
 rtl/iop_edge.sv | 31 +++
 rtl/iot_device_port.sv | 116 +++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the positive I/O bus: bus widths, IOP line
// indices and the standard device codes used by the console devices.
package io_bus_pkg;

  localparam int DEV_CODE_W = 6;
  localparam int BUS_W      = 12;

  localparam int NUM_IOP  = 3;
  localparam int IOP1_IDX = 0;
  localparam int IOP2_IDX = 1;
  localparam int IOP4_IDX = 2;

  typedef logic [BUS_W-1:0]      bus_word_t;
  typedef logic [DEV_CODE_W-1:0] dev_code_t;

  localparam dev_code_t DEV_KB     = 6'o03;
  localparam dev_code_t DEV_TTY    = 6'o04;
  localparam dev_code_t DEV_READER = 6'o01;
  localparam dev_code_t DEV_PUNCH  = 6'o02;

endpackage

// File: rtl/iop_edge.sv
// Registers one IOP line and produces a single-cycle pulse on its rising
// edge. armed_q keeps a line that is already high when reset releases from
// being mistaken for a fresh pulse: the first cycle only samples the line.
module iop_edge (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic line_i,
  output logic rise_o
);

  logic line_q;
  logic armed_q;

  // Previous line level plus the post-reset arming flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q  <= 1'b0;
      armed_q <= 1'b0;
    end else if (init) begin
      line_q  <= 1'b0;
      armed_q <= armed_q;
    end else begin
      line_q  <= line_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q & line_i & ~line_q;

endmodule

// File: rtl/iot_device_port.sv
// Peripheral endpoint on the positive I/O bus. Decodes its device code from
// the MB select bits, acts once per IOP pulse, and holds the device flag,
// data buffer, overrun flag and interrupt request for one device.
module iot_device_port
  import io_bus_pkg::*;
#(
  parameter dev_code_t DEV_CODE  = 6'o03,
  parameter bit        IS_OUTPUT = 1'b0,
  parameter int        WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [DEV_CODE_W-1:0] bmb,
  input  logic                  iop1,
  input  logic                  iop2,
  input  logic                  iop4,
  input  logic [BUS_W-1:0]      bac,
  output logic                  skip,
  output logic                  ac_clear,
  output logic [BUS_W-1:0]      io_in,
  output logic                  int_rq,
  input  logic                  dev_load,
  input  logic [WIDTH-1:0]      dev_data,
  output logic [WIDTH-1:0]      dev_out,
  output logic                  dev_start,
  output logic                  overrun
);

  logic [NUM_IOP-1:0] rise;
  logic               sel;
  logic               sig_unused;

  logic             flag_q,    flag_d;
  logic             ovr_q,     ovr_d;
  logic [WIDTH-1:0] buf_q,     buf_d;
  logic             start_q,   start_d;
  logic             int_rq_q,  int_rq_d;
  logic             int_en_q;

  iop_edge u_iop1 (.clk(clk), .rst(rst), .init(init), .line_i(iop1), .rise_o(rise[IOP1_IDX]));
  iop_edge u_iop2 (.clk(clk), .rst(rst), .init(init), .line_i(iop2), .rise_o(rise[IOP2_IDX]));
  iop_edge u_iop4 (.clk(clk), .rst(rst), .init(init), .line_i(iop4), .rise_o(rise[IOP4_IDX]));

  assign sel = (bmb == DEV_CODE);

  // IOP1 only tests the flag, so its edge and the upper AC bits carry no state
  assign sig_unused = ^{bac, rise[IOP1_IDX]};

  // Next-state logic: a device strobe is applied last so a set beats a clear
  always_comb begin
    flag_d   = flag_q;
    ovr_d    = ovr_q;
    buf_d    = buf_q;
    start_d  = 1'b0;
    int_rq_d = flag_q & int_en_q;
    if (sel && rise[IOP2_IDX]) begin
      flag_d = 1'b0;
    end
    if (IS_OUTPUT && sel && rise[IOP4_IDX]) begin
      buf_d   = bac[WIDTH-1:0];
      start_d = 1'b1;
    end
    if (dev_load) begin
      flag_d = 1'b1;
      if (flag_q) begin
        ovr_d = 1'b1;
      end
      if (!IS_OUTPUT) begin
        buf_d = dev_data;
      end
    end
  end

  // Device state registers; bus initialize clears them like reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q   <= 1'b0;
      ovr_q    <= 1'b0;
      buf_q    <= '0;
      start_q  <= 1'b0;
      int_rq_q <= 1'b0;
      int_en_q <= 1'b1;
    end else if (init) begin
      flag_q   <= 1'b0;
      ovr_q    <= 1'b0;
      buf_q    <= '0;
      start_q  <= 1'b0;
      int_rq_q <= 1'b0;
      int_en_q <= 1'b1;
    end else begin
      flag_q   <= flag_d;
      ovr_q    <= ovr_d;
      buf_q    <= buf_d;
      start_q  <= start_d;
      int_rq_q <= int_rq_d;
      int_en_q <= int_en_q;
    end
  end

  // Return-bus levels follow the live IOP lines while this device is selected
  always_comb begin
    io_in = '0;
    if (sel && iop4 && !IS_OUTPUT) begin
      io_in[WIDTH-1:0] = buf_q;
    end
  end

  assign skip      = sel & iop1 & flag_q;
  assign ac_clear  = sel & iop2 & ~IS_OUTPUT;
  assign int_rq    = int_rq_q;
  assign dev_out   = buf_q;
  assign dev_start = start_q;
  assign overrun   = ovr_q;

endmodule
